// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport integer register file.
package rf_pkg;

    // Post-reset clear engine states.
    typedef enum logic [0:0] {
        CLR = 1'b0,
        RDY = 1'b1
    } clr_state_e;

    // Lane whose write wins when both retire lanes target the same entry.
    localparam int RF_HI_LANE = 1;

    // Ceiling log2, never less than 1 so a 2-entry file still has an address bit.
    function automatic int rf_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Sequential clear engine: walks every entry once after reset, then flags ready.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = rf_clog2(NREGS)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx,
    output logic          ready
);

    clr_state_e    state_r;
    clr_state_e    state_nxt_s;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] idx_nxt_s;
    logic          ready_r;

    // Next-state and index advance; the last entry cleared moves us to RDY.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            CLR: begin
                if (idx_r == AW'(NREGS - 1)) begin
                    state_nxt_s = RDY;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = CLR;
                    idx_nxt_s   = idx_r + AW'(1);
                end
            end
            RDY: begin
                state_nxt_s = RDY;
                idx_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = CLR;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // State, index and registered ready flag; reset restarts the sweep at entry 0.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r <= CLR;
            idx_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            ready_r <= (state_nxt_s == RDY);
        end
    end

    assign clr_en  = rst_in && (state_r == CLR);
    assign clr_idx = idx_r;
    assign ready   = ready_r;

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: two prioritised write lanes, bypassed reads,
// per-entry pending scoreboard and a post-reset clear sweep.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = rf_clog2(NREGS)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NRD*AW-1:0]   rs_addr_in,
    output logic [NRD*XLEN-1:0] rs_data_out,
    output logic [NRD-1:0]      rs_pend_out,
    input  logic                wr0_en_in,
    input  logic [AW-1:0]       wr0_addr_in,
    input  logic [XLEN-1:0]     wr0_data_in,
    input  logic                wr1_en_in,
    input  logic [AW-1:0]       wr1_addr_in,
    input  logic [XLEN-1:0]     wr1_data_in,
    input  logic                iss_en_in,
    input  logic [AW-1:0]       iss_addr_in,
    output logic                ready_out
);

    localparam int HI = RF_HI_LANE;
    localparam int LO = 1 - RF_HI_LANE;

    logic            clr_en_s;
    logic [AW-1:0]   clr_idx_s;
    logic            ready_s;
    logic [XLEN-1:0] mem_r [NREGS];
    logic [NREGS-1:0] pend_r;
    logic [NREGS-1:0] pend_nxt_s;
    logic            wr_ok_s   [2];
    logic [AW-1:0]   wr_addr_s [2];
    logic [XLEN-1:0] wr_data_s [2];
    logic            iss_ok_s;

    // Entry exists and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    rf_clear_ctrl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_en  (clr_en_s),
        .clr_idx (clr_idx_s),
        .ready   (ready_s)
    );

    assign ready_out = ready_s;

    // Qualify both retire lanes and the issue mark; nothing lands before ready.
    always_comb begin
        wr_addr_s[0] = wr0_addr_in;
        wr_addr_s[1] = wr1_addr_in;
        wr_data_s[0] = wr0_data_in;
        wr_data_s[1] = wr1_data_in;
        wr_ok_s[0]   = ready_s && wr0_en_in && addr_ok(wr0_addr_in);
        wr_ok_s[1]   = ready_s && wr1_en_in && addr_ok(wr1_addr_in);
        iss_ok_s     = ready_s && iss_en_in && addr_ok(iss_addr_in);
    end

    // Array update: clear sweep, else low lane then high lane so high lane wins.
    always_ff @(posedge clk_in) begin
        if (clr_en_s) begin
            mem_r[clr_idx_s] <= '0;
        end else begin
            if (wr_ok_s[LO]) begin
                mem_r[wr_addr_s[LO]] <= wr_data_s[LO];
            end
            if (wr_ok_s[HI]) begin
                mem_r[wr_addr_s[HI]] <= wr_data_s[HI];
            end
        end
    end

    // Pending next value: a new issue mark outranks a same-cycle retire clear.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 0; i < NREGS; i++) begin
            pend_nxt_s[i] = (iss_ok_s && (int'(iss_addr_in) == i)) ||
                            (pend_r[i] &&
                             !((wr_ok_s[0] && (int'(wr_addr_s[0]) == i)) ||
                               (wr_ok_s[1] && (int'(wr_addr_s[1]) == i))));
        end
    end

    // Pending scoreboard register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra_s;
        logic [XLEN-1:0] rd_s;
        logic            pd_s;
        logic            hit_hi_s;
        logic            hit_lo_s;

        assign ra_s = rs_addr_in[k*AW +: AW];

        // Read mux with same-cycle write bypass; a retiring write hides pending.
        always_comb begin
            rd_s     = '0;
            pd_s     = 1'b0;
            hit_hi_s = wr_ok_s[HI] && (wr_addr_s[HI] == ra_s);
            hit_lo_s = wr_ok_s[LO] && (wr_addr_s[LO] == ra_s);
            if (ready_s && addr_ok(ra_s)) begin
                if (hit_hi_s) begin
                    rd_s = wr_data_s[HI];
                end else if (hit_lo_s) begin
                    rd_s = wr_data_s[LO];
                end else begin
                    rd_s = mem_r[ra_s];
                end
                pd_s = pend_r[ra_s] && !(hit_hi_s || hit_lo_s);
            end else begin
                rd_s = '0;
                pd_s = 1'b0;
            end
        end

        assign rs_data_out[k*XLEN +: XLEN] = rd_s;
        assign rs_pend_out[k]              = pd_s;
    end

endmodule
